// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101
  } load_type_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_WAIT0,
    S_ACC1,
    S_WAIT1,
    S_RESP
  } lsu_state_e;

  // Access size in bytes; 0 marks an invalid type encoding.
  function automatic logic [2:0] access_size(input logic we, input logic [2:0] lt,
                                             input logic [1:0] st);
    logic [2:0] sz;
    sz = 3'd0;
    if (we) begin
      case (st)
        ST_SB:   sz = 3'd1;
        ST_SH:   sz = 3'd2;
        ST_SW:   sz = 3'd4;
        default: sz = 3'd0;
      endcase
    end else begin
      case (lt)
        LD_LB, LD_LBU: sz = 3'd1;
        LD_LH, LD_LHU: sz = 3'd2;
        LD_LW:         sz = 3'd4;
        default:       sz = 3'd0;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_split(input logic [1:0] off, input logic [2:0] sz);
    return ({2'b00, off} + {1'b0, sz}) > 4'd4;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] sz);
    return is_split(off, sz) || ((sz == 3'd2) && off[0]);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment: write strobes/data for both words and
// extended load data assembled from the two sampled words.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic        split,
  output logic [3:0]  strb0,
  output logic [3:0]  strb1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata_ext
);

  logic [2:0]  size;
  logic [3:0]  bmask;
  logic [7:0]  smask;
  logic [31:0] dmask;
  logic [63:0] wwide;
  logic [63:0] rwide;
  logic [31:0] rlow;

  assign size  = access_size(we, load_type, store_type);
  assign split = is_split(off, size);

  always_comb begin
    bmask = 4'h0;
    case (size)
      3'd1:    bmask = 4'h1;
      3'd2:    bmask = 4'h3;
      3'd4:    bmask = 4'hF;
      default: bmask = 4'h0;
    endcase
    dmask = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
    // A 64-bit window spanning both words turns the split into a plain shift.
    smask = {4'h0, bmask} << off;
    wwide = {32'h0, wdata & dmask} << {off, 3'b000};
    rwide = {rdata1, rdata0} >> {off, 3'b000};
    rlow  = rwide[31:0];
    strb0  = smask[3:0];
    strb1  = smask[7:4];
    wdata0 = wwide[31:0];
    wdata1 = wwide[63:32];
  end

  always_comb begin
    rdata_ext = '0;
    case (load_type)
      LD_LB:   rdata_ext = {{24{rlow[7]}}, rlow[7:0]};
      LD_LH:   rdata_ext = {{16{rlow[15]}}, rlow[15:0]};
      LD_LW:   rdata_ext = rlow;
      LD_LBU:  rdata_ext = {24'h0, rlow[7:0]};
      LD_LHU:  rdata_ext = {16'h0, rlow[15:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-organised data RAM; splits misaligned accesses.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with rsp_err instead.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_load_type,
  input  logic [1:0]        req_store_type,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ce,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  lsu_state_e state, state_nx;

  logic              we_q;
  logic [2:0]        ltype_q;
  logic [1:0]        stype_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr0_q;
  logic [ADDR_W-1:0] addr1;
  logic              err_q;
  logic [31:0]       rd0_q;
  logic [31:0]       rd1_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wait_done;
  logic              accept;
  logic              req_err;
  logic [2:0]        req_size;

  logic        split;
  logic [3:0]  strb0, strb1;
  logic [31:0] wdata0, wdata1, rdata_ext;

  lsu_lane_align u_align (
    .we         (we_q),
    .load_type  (ltype_q),
    .store_type (stype_q),
    .off        (off_q),
    .wdata      (wdata_q),
    .rdata0     (rd0_q),
    .rdata1     (rd1_q),
    .split      (split),
    .strb0      (strb0),
    .strb1      (strb1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .rdata_ext  (rdata_ext)
  );

  assign accept    = req_valid && req_ready;
  assign req_size  = access_size(req_we, req_load_type, req_store_type);
`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err   = (req_size == 3'd0) || is_misaligned(req_addr[1:0], req_size);
`else
  assign req_err   = (req_size == 3'd0);
`endif
  assign addr1     = addr0_q + ADDR_W'(WORD_BYTES);
  assign wait_done = (cnt_q == CNT_W'(RD_LAT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = req_err ? S_RESP : S_ACC0;
      S_ACC0:  state_nx = we_q ? (split ? S_ACC1 : S_RESP) : S_WAIT0;
      S_WAIT0: if (wait_done) state_nx = split ? S_ACC1 : S_RESP;
      S_ACC1:  state_nx = we_q ? S_RESP : S_WAIT1;
      S_WAIT1: if (wait_done) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE) && reset;
    mem_ce    = (state == S_ACC0) || (state == S_ACC1);
    mem_wr_en = mem_ce && we_q;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (state == S_ACC0) mem_addr = addr0_q;
    if (state == S_ACC1) mem_addr = addr1;
    if (mem_wr_en) begin
      mem_wstrb = (state == S_ACC0) ? strb0 : strb1;
      mem_wdata = (state == S_ACC0) ? wdata0 : wdata1;
    end
    rsp_valid = (state == S_RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? rdata_ext : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      ltype_q <= '0;
      stype_q <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      addr0_q <= '0;
      err_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        ltype_q <= req_load_type;
        stype_q <= req_store_type;
        off_q   <= req_addr[1:0];
        wdata_q <= req_wdata;
        addr0_q <= {req_addr[ADDR_W-1:2], 2'b00};
        err_q   <= req_err;
      end
      if ((state == S_WAIT0 || state == S_WAIT1) && !wait_done) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (state == S_WAIT0 && wait_done) rd0_q <= mem_rdata;
      if (state == S_WAIT1 && wait_done) rd1_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a behavioural 256-byte RAM.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_load_type;
  logic [1:0]  req_store_type;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_ce;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:63];

  int          rsp_cyc;
  int          n_ce;
  logic [31:0] got_rdata;
  logic        got_err;
  logic        rsp_after;
  logic [7:0]  ce_addr  [0:1];
  logic [3:0]  ce_strb  [0:1];
  logic [31:0] ce_wdata [0:1];
  logic        ce_wr    [0:1];

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(8), .RD_LAT(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_load_type  (req_load_type),
    .req_store_type (req_store_type),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_ce         (mem_ce),
    .mem_wr_en      (mem_wr_en),
    .mem_addr       (mem_addr),
    .mem_wstrb      (mem_wstrb),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'h8765_4321;
    mem[2] = 32'h9999_9999;
    mem_rdata = 32'h0;
  end

  // One-cycle read latency RAM with byte strobes.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[7:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] lt, input logic [1:0] st);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    req_we         = we;
    req_addr       = addr;
    req_wdata      = wdata;
    req_load_type  = lt;
    req_store_type = st;
    req_valid      = 1'b1;
    @(posedge clk);
    #1;
    req_valid      = 1'b0;
    req_addr       = $urandom;
    req_wdata      = $urandom;
    req_we         = 1'($urandom);
    req_load_type  = 3'($urandom);
    req_store_type = 2'($urandom);
    n_ce      = 0;
    rsp_cyc   = -1;
    got_rdata = 32'hDEAD_BEEF;
    got_err   = 1'bx;
    rsp_after = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      if (mem_ce) begin
        if (n_ce < 2) begin
          ce_addr[n_ce]  = mem_addr;
          ce_strb[n_ce]  = mem_wstrb;
          ce_wdata[n_ce] = mem_wdata;
          ce_wr[n_ce]    = mem_wr_en;
        end
        n_ce++;
      end
      if (rsp_valid) begin
        rsp_cyc   = c;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    rsp_after = rsp_valid;
  endtask

  task automatic expect_txn(input string tag, input int cyc, input int nce,
                            input logic [31:0] rdata, input logic err);
    check({tag, " rsp cycle"}, 32'(rsp_cyc), 32'(cyc));
    check({tag, " mem_ce count"}, 32'(n_ce), 32'(nce));
    check({tag, " rsp_rdata"}, got_rdata, rdata);
    check({tag, " rsp_err"}, {31'h0, got_err}, {31'h0, err});
    check({tag, " rsp pulse width"}, {31'h0, rsp_after}, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_load_type = '0;
    req_store_type = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", {31'h0, req_ready}, 32'h0);
    check("reset outputs", {24'h0, rsp_valid, rsp_err, mem_ce, mem_wr_en, mem_wstrb}, 32'h0);
    check("reset rdata/addr", rsp_rdata | {24'h0, mem_addr} | mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle req_ready", {31'h0, req_ready}, 32'h1);

    run_req(1'b0, 32'h05, 32'h0, 3'b000, 2'b00);
    expect_txn("LB 05", 3, 1, 32'h0000_0043, 1'b0);
    check("LB 05 addr", {24'h0, ce_addr[0]}, 32'h04);
    check("LB 05 rd strb", {27'h0, ce_wr[0], ce_strb[0]}, 32'h0);

    run_req(1'b0, 32'h07, 32'h0, 3'b000, 2'b00);
    expect_txn("LB 07", 3, 1, 32'hFFFF_FF87, 1'b0);
    run_req(1'b0, 32'h07, 32'h0, 3'b100, 2'b00);
    expect_txn("LBU 07", 3, 1, 32'h0000_0087, 1'b0);
    run_req(1'b0, 32'h06, 32'h0, 3'b001, 2'b00);
    expect_txn("LH 06", 3, 1, 32'hFFFF_8765, 1'b0);

    run_req(1'b0, 32'h06, 32'h0, 3'b010, 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    expect_txn("LW 06 trap", 1, 0, 32'h0, 1'b1);
`else
    expect_txn("LW 06 split", 5, 2, 32'h9999_8765, 1'b0);
    check("LW 06 addr0", {24'h0, ce_addr[0]}, 32'h04);
    check("LW 06 addr1", {24'h0, ce_addr[1]}, 32'h08);
`endif

    // Reset while the load sits in WAIT0.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h04; req_load_type = 3'b010; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async reset outputs",
          {24'h0, rsp_valid, rsp_err, mem_ce, mem_wr_en, mem_wstrb}, 32'h0);
    check("async reset data", rsp_rdata | {24'h0, mem_addr} | mem_wdata, 32'h0);
    check("async reset ready", {31'h0, req_ready}, 32'h0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (2) begin
        @(posedge clk);
        #1;
        seen = seen | rsp_valid;
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
        @(posedge clk);
        #1;
        seen = seen | rsp_valid;
      end
      check("no rsp after abort", {31'h0, seen}, 32'h0);
    end
    run_req(1'b0, 32'h04, 32'h0, 3'b010, 2'b00);
    expect_txn("LW 04 post-reset", 3, 1, 32'h8765_4321, 1'b0);

    run_req(1'b1, 32'h06, 32'h0000_00AB, 3'b000, 2'b00);
    expect_txn("SB 06", 2, 1, 32'h0, 1'b0);
    check("SB 06 strb", {27'h0, ce_wr[0], ce_strb[0]}, 32'h14);
    check("SB 06 byte", {24'h0, ce_wdata[0][23:16]}, 32'hAB);
    run_req(1'b0, 32'h04, 32'h0, 3'b010, 2'b00);
    expect_txn("LW 04 after SB", 3, 1, 32'h87AB_4321, 1'b0);

    run_req(1'b1, 32'hFF, 32'h0000_1234, 3'b000, 2'b01);
`ifdef LSU_MISALIGN_TRAP_EN
    expect_txn("SH FF trap", 1, 0, 32'h0, 1'b1);
    run_req(1'b0, 32'h00, 32'h0, 3'b010, 2'b00);
    expect_txn("LW 00", 3, 1, 32'h0, 1'b0);
    run_req(1'b0, 32'hFC, 32'h0, 3'b010, 2'b00);
    expect_txn("LW FC", 3, 1, 32'h0, 1'b0);
`else
    expect_txn("SH FF split", 3, 2, 32'h0, 1'b0);
    check("SH FF addr0", {24'h0, ce_addr[0]}, 32'hFC);
    check("SH FF strb0", {28'h0, ce_strb[0]}, 32'h8);
    check("SH FF byte0", {24'h0, ce_wdata[0][31:24]}, 32'h34);
    check("SH FF addr1", {24'h0, ce_addr[1]}, 32'h00);
    check("SH FF strb1", {28'h0, ce_strb[1]}, 32'h1);
    check("SH FF byte1", {24'h0, ce_wdata[1][7:0]}, 32'h12);
    run_req(1'b0, 32'h00, 32'h0, 3'b010, 2'b00);
    expect_txn("LW 00", 3, 1, 32'h0000_0012, 1'b0);
    run_req(1'b0, 32'hFC, 32'h0, 3'b010, 2'b00);
    expect_txn("LW FC", 3, 1, 32'h3400_0000, 1'b0);
`endif

    run_req(1'b0, 32'h04, 32'h0, 3'b011, 2'b00);
    expect_txn("bad load type", 1, 0, 32'h0, 1'b1);
    run_req(1'b1, 32'h04, 32'hFFFF_FFFF, 3'b000, 2'b11);
    expect_txn("bad store type", 1, 0, 32'h0, 1'b1);
    check("bad store mem intact", mem[1], 32'h87AB_4321);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
